// File: rtl/register_bank.sv
// register_bank: per-core SIMD register file serving THREADS lanes.
// Each lane holds NUM_REGS registers; the top three are read-only
// (latched block id, latched block dim, lane index). A small IDLE/CLEAR
// sequencer zeroes the writable registers at block dispatch.
// Optional feature macro: REGISTER_BANK_ZERO_REG_EN (R0 hardwired to zero).
module register_bank #(
  parameter int DATA_BITS = 8,
  parameter int THREADS   = 4,
  parameter int NUM_REGS  = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [2:0]                     core_state,
  input  logic [THREADS-1:0]             thread_enable,
  input  logic                           clear_req,
  input  logic [DATA_BITS-1:0]           block_id,
  input  logic [DATA_BITS-1:0]           block_dim,
  input  logic                           decoded_reg_write_enable,
  input  logic [1:0]                     decoded_reg_input_mux,
  input  logic [$clog2(NUM_REGS)-1:0]    decoded_rd_address,
  input  logic [$clog2(NUM_REGS)-1:0]    decoded_rs_address,
  input  logic [$clog2(NUM_REGS)-1:0]    decoded_rt_address,
  input  logic [DATA_BITS-1:0]           decoded_immediate,
  input  logic [THREADS*DATA_BITS-1:0]   alu_out,
  input  logic [THREADS*DATA_BITS-1:0]   lsu_out,
  output logic [THREADS*DATA_BITS-1:0]   rs,
  output logic [THREADS*DATA_BITS-1:0]   rt,
  output logic                           busy
);

  localparam int ADDR_BITS = $clog2(NUM_REGS);

  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

  localparam logic [ADDR_BITS-1:0] ID_ADDR   = ADDR_BITS'(NUM_REGS - 3);
  localparam logic [ADDR_BITS-1:0] DIM_ADDR  = ADDR_BITS'(NUM_REGS - 2);
  localparam logic [ADDR_BITS-1:0] LANE_ADDR = ADDR_BITS'(NUM_REGS - 1);
  localparam logic [ADDR_BITS-1:0] LAST_WR   = ADDR_BITS'(NUM_REGS - 4);

`ifdef REGISTER_BANK_ZERO_REG_EN
  localparam logic [ADDR_BITS-1:0] CLEAR_START = ADDR_BITS'(1);
`else
  localparam logic [ADDR_BITS-1:0] CLEAR_START = '0;
`endif

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_CLEAR = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   counter_q, counter_d;
  logic                   latch_en;
  logic [DATA_BITS-1:0]   block_id_q, block_dim_q;
  logic                   write_ok;
  logic                   read_req;

  // Resolve a read address to the read-only sources or the stored value.
  function automatic logic [DATA_BITS-1:0] pick(
    input logic [ADDR_BITS-1:0] addr,
    input logic [DATA_BITS-1:0] stored,
    input logic [DATA_BITS-1:0] lane_value,
    input logic [DATA_BITS-1:0] id_value,
    input logic [DATA_BITS-1:0] dim_value
  );
    logic [DATA_BITS-1:0] result;
    if (addr == LANE_ADDR)     result = lane_value;
    else if (addr == DIM_ADDR) result = dim_value;
    else if (addr == ID_ADDR)  result = id_value;
`ifdef REGISTER_BANK_ZERO_REG_EN
    else if (addr == '0)       result = '0;
`endif
    else                       result = stored;
    return result;
  endfunction

  assign busy     = (state_q == S_CLEAR);
  assign read_req = (core_state == REQUEST);

  // Lane-independent part of the write qualification.
  always_comb begin
    write_ok = (core_state == UPDATE) && !busy && decoded_reg_write_enable &&
               (decoded_reg_input_mux != 2'b11) && (decoded_rd_address < ID_ADDR);
`ifdef REGISTER_BANK_ZERO_REG_EN
    if (decoded_rd_address == '0) write_ok = 1'b0;
`endif
  end

  // Clear sequencer state register; reset aborts any sequence in progress.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      counter_q <= '0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
    end
  end

  // Clear sequencer next state: walk the writable registers once per request.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    latch_en  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (clear_req) begin
          state_d   = S_CLEAR;
          counter_d = CLEAR_START;
          latch_en  = 1'b1;
        end
      end
      S_CLEAR: begin
        counter_d = counter_q + 1'b1;
        if (counter_q == LAST_WR) begin
          state_d   = S_IDLE;
          counter_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Capture the dispatched block's id and dimension when a clear is accepted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      block_id_q  <= '0;
      block_dim_q <= '0;
    end else if (latch_en) begin
      block_id_q  <= block_id;
      block_dim_q <= block_dim;
    end
  end

  for (genvar l = 0; l < THREADS; l++) begin : g_lane
    localparam logic [DATA_BITS-1:0] LANE_VALUE = DATA_BITS'(l);

    logic [DATA_BITS-1:0] regs [NUM_REGS];
    logic [DATA_BITS-1:0] src;
    logic [DATA_BITS-1:0] rs_val, rt_val;
    logic [DATA_BITS-1:0] rs_q, rt_q;

    // Select this lane's write-back source.
    always_comb begin
      src = '0;
      case (decoded_reg_input_mux)
        2'b00:   src = alu_out[l*DATA_BITS +: DATA_BITS];
        2'b01:   src = lsu_out[l*DATA_BITS +: DATA_BITS];
        2'b10:   src = decoded_immediate;
        default: src = '0;
      endcase
    end

    // Decode both source operands for this lane.
    always_comb begin
      rs_val = pick(decoded_rs_address, regs[decoded_rs_address], LANE_VALUE,
                    block_id_q, block_dim_q);
      rt_val = pick(decoded_rt_address, regs[decoded_rt_address], LANE_VALUE,
                    block_id_q, block_dim_q);
    end

    // Register storage: clear sequencer has priority over masked write-back.
    always_ff @(posedge clk) begin
      if (!reset) begin
        for (int r = 0; r < NUM_REGS; r++) regs[r] <= '0;
      end else if (busy) begin
        regs[counter_q] <= '0;
      end else if (write_ok && thread_enable[l]) begin
        regs[decoded_rd_address] <= src;
      end
    end

    // Operand latches: enabled lanes load on REQUEST, disabled lanes hold.
    always_ff @(posedge clk) begin
      if (!reset) begin
        rs_q <= '0;
        rt_q <= '0;
      end else if (read_req && thread_enable[l]) begin
        rs_q <= rs_val;
        rt_q <= rt_val;
      end
    end

    assign rs[l*DATA_BITS +: DATA_BITS] = rs_q;
    assign rt[l*DATA_BITS +: DATA_BITS] = rt_q;
  end

endmodule

// File: tb/tb_register_bank.sv
// Directed self-checking bench for register_bank (THREADS=4, DATA_BITS=8,
// NUM_REGS=16). Honours REGISTER_BANK_ZERO_REG_EN when compiled with it.
module tb_register_bank;

  localparam logic [2:0] REQUEST = 3'b011;
  localparam logic [2:0] UPDATE  = 3'b110;

`ifdef REGISTER_BANK_ZERO_REG_EN
  localparam int          BUSY_LEN = 12;
  localparam logic [31:0] R0_IMM   = 32'h0000_0000;
`else
  localparam int          BUSY_LEN = 13;
  localparam logic [31:0] R0_IMM   = 32'h5A5A_5A5A;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  core_state;
  logic [3:0]  thread_enable;
  logic        clear_req;
  logic [7:0]  block_id, block_dim;
  logic        we;
  logic [1:0]  mux;
  logic [3:0]  rd_addr, rs_addr, rt_addr;
  logic [7:0]  imm;
  logic [31:0] alu_out, lsu_out;
  logic [31:0] rs, rt;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int n;

  register_bank #(.DATA_BITS(8), .THREADS(4), .NUM_REGS(16)) dut (
    .clk(clk), .reset(reset), .core_state(core_state),
    .thread_enable(thread_enable), .clear_req(clear_req),
    .block_id(block_id), .block_dim(block_dim),
    .decoded_reg_write_enable(we), .decoded_reg_input_mux(mux),
    .decoded_rd_address(rd_addr), .decoded_rs_address(rs_addr),
    .decoded_rt_address(rt_addr), .decoded_immediate(imm),
    .alu_out(alu_out), .lsu_out(lsu_out),
    .rs(rs), .rt(rt), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    core_state    = 3'b000;
    we            = 1'b0;
    mux           = 2'b11;
    clear_req     = 1'b0;
    thread_enable = 4'b1111;
  endtask

  task automatic writeReg(input logic [3:0] rd, input logic [1:0] m,
                          input logic [31:0] alu, input logic [31:0] lsu,
                          input logic [7:0] im, input logic [3:0] mask);
    core_state = UPDATE; we = 1'b1; mux = m; rd_addr = rd;
    alu_out = alu; lsu_out = lsu; imm = im; thread_enable = mask;
    tick();
    idleInputs();
  endtask

  task automatic readReg(input logic [3:0] a, input logic [3:0] b,
                         input logic [3:0] mask);
    core_state = REQUEST; rs_addr = a; rt_addr = b; thread_enable = mask;
    tick();
    idleInputs();
  endtask

  initial begin
    idleInputs();
    reset = 1'b0; block_id = 8'h00; block_dim = 8'h00;
    rd_addr = '0; rs_addr = '0; rt_addr = '0; imm = '0;
    alu_out = '0; lsu_out = '0;
    tick(); tick();
    checkOutput("reset_rs", rs, 32'h0);
    checkOutput("reset_rt", rt, 32'h0);
    checkOutput("reset_busy", busy, 1'b0);
    reset = 1'b1;
    tick();

    readReg(4'd15, 4'd13, 4'b1111);
    checkOutput("lane_index", rs, 32'h0302_0100);
    checkOutput("block_id_reset", rt, 32'h0);

    writeReg(4'd5, 2'b00, 32'h4433_2211, 32'h0, 8'h00, 4'b0101);
    readReg(4'd5, 4'd5, 4'b1111);
    checkOutput("masked_write", rs, 32'h0033_0011);

    readReg(4'd15, 4'd15, 4'b0001);
    checkOutput("masked_read_hold", rs, 32'h0033_0000);

    writeReg(4'd3, 2'b01, 32'h0, 32'hDDCC_BBAA, 8'h00, 4'b1111);
    writeReg(4'd4, 2'b10, 32'h0, 32'h0, 8'h5A, 4'b1111);
    readReg(4'd3, 4'd4, 4'b1111);
    checkOutput("lsu_write", rs, 32'hDDCC_BBAA);
    checkOutput("imm_write", rt, 32'h5A5A_5A5A);

    writeReg(4'd3, 2'b11, 32'h1111_1111, 32'h0, 8'h00, 4'b1111);
    we = 1'b0; core_state = UPDATE; mux = 2'b10; rd_addr = 4'd3; imm = 8'h99;
    tick();
    idleInputs();
    readReg(4'd3, 4'd3, 4'b1111);
    checkOutput("no_write_mux11_we0", rs, 32'hDDCC_BBAA);

    writeReg(4'd14, 2'b10, 32'h0, 32'h0, 8'hAA, 4'b1111);
    writeReg(4'd15, 2'b10, 32'h0, 32'h0, 8'hAA, 4'b1111);
    readReg(4'd14, 4'd15, 4'b1111);
    checkOutput("ro_dim", rs, 32'h0);
    checkOutput("ro_lane", rt, 32'h0302_0100);

    writeReg(4'd0, 2'b10, 32'h0, 32'h0, 8'h5A, 4'b1111);
    readReg(4'd0, 4'd0, 4'b1111);
    checkOutput("r0_imm", rs, R0_IMM);

    for (int r = 0; r <= 12; r++)
      writeReg(4'(r), 2'b10, 32'h0, 32'h0, 8'hFF, 4'b1111);
    readReg(4'd12, 4'd1, 4'b1111);
    checkOutput("fill_r12", rs, 32'hFFFF_FFFF);

    block_id = 8'd7; block_dim = 8'd4; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 5) begin
        clear_req = 1'b1; block_id = 8'd9; block_dim = 8'd9;
        core_state = UPDATE; we = 1'b1; mux = 2'b10; rd_addr = 4'd0;
        imm = 8'h77;
      end
      tick();
      idleInputs();
    end
    checkOutput("busy_len", n, BUSY_LEN);
    for (int r = 0; r <= 12; r++) begin
      readReg(4'(r), 4'(r), 4'b1111);
      checkOutput($sformatf("cleared_r%0d", r), rs, 32'h0);
    end
    readReg(4'd13, 4'd14, 4'b1111);
    checkOutput("latched_id", rs, 32'h0707_0707);
    checkOutput("latched_dim", rt, 32'h0404_0404);

    writeReg(4'd7, 2'b10, 32'h0, 32'h0, 8'h21, 4'b1111);
    block_id = 8'h12; block_dim = 8'h34; clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    checkOutput("busy_rise", busy, 1'b1);
    for (int k = 0; k < 4; k++) tick();
    reset = 1'b0;
    tick();
    checkOutput("midclear_reset_busy", busy, 1'b0);
    checkOutput("midclear_reset_rs", rs, 32'h0);
    reset = 1'b1;
    tick();
    checkOutput("idle_after_reset", busy, 1'b0);
    readReg(4'd7, 4'd13, 4'b1111);
    checkOutput("reset_r7", rs, 32'h0);
    checkOutput("reset_id", rt, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
